// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
// Pointer width, read-mode selectors and default sizes.
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  localparam int DEF_DSIZE = 8;
  localparam int DEF_ASIZE = 4;

  // One extra wrap bit above the address.
  function automatic int ptr_w(input int asize);
    return asize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Single-clock simple dual-port RAM.
// The read port is registered (standard) or combinational (FWFT).
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DSIZE = DEF_DSIZE,
  parameter int ASIZE = DEF_ASIZE,
  parameter int FWFT  = FIFO_STD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic             i_re,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  logic [DSIZE-1:0] r_mem [2**ASIZE];
  logic [DSIZE-1:0] r_rdata;

  // Storage is never reset; only the write port touches it.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read word, held between accepted reads.
  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = (FWFT == FIFO_FWFT) ? r_mem[i_raddr] : r_rdata;

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost flags,
// selectable FWFT read and sticky overflow/underflow.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int DSIZE     = DEF_DSIZE,
  parameter int ASIZE     = DEF_ASIZE,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  output logic             wfull,
  output logic             walmost_full,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             rempty,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = ptr_w(ASIZE);
  localparam logic [PW-1:0] DEPTH = PW'(2**ASIZE);
  localparam logic [PW-1:0] AF_TH = PW'(AFULL_TH);
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_TH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic          r_ovf;
  logic          r_unf;
  logic          w_wr_ok;
  logic          w_rd_ok;

  // Acceptance uses the pre-edge flags only; no bypass paths.
  assign w_wr_ok = winc & ~wfull;
  assign w_rd_ok = rinc & ~rempty;

  // Binary pointers advance on accepted accesses and wrap freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
    end
  end

  // Fill level: +1 on write, -1 on read, unchanged on both.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_ok && !w_rd_ok) begin
      r_count <= r_count + 1'b1;
    end else if (!w_wr_ok && w_rd_ok) begin
      r_count <= r_count - 1'b1;
    end
  end

  // Sticky errors; a new error beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (winc && wfull) r_ovf <= 1'b1;
      else if (err_clr)  r_ovf <= 1'b0;
      if (rinc && rempty) r_unf <= 1'b1;
      else if (err_clr)   r_unf <= 1'b0;
    end
  end

  assign count         = r_count;
  assign wfull         = (r_count == DEPTH);
  assign rempty        = (r_count == '0);
  assign walmost_full  = (r_count >= AF_TH);
  assign ralmost_empty = (r_count <= AE_TH);
  assign overflow      = r_ovf;
  assign underflow     = r_unf;

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE),
    .FWFT  (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_re    (w_rd_ok),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (rdata)
  );

endmodule
